multu_seq: RTL and testbench
============================

# multu_seq

Iterative 32x32 unsigned shift-add multiplier with its own HI/LO result registers. It sits between the register-file read ports (srca/srcb) and the MFHI/MFLO result mux, replacing the single-cycle combinational product. While a MULTU is in progress it drives a stall that holds the PC and suppresses register-file and memory writes. HI/LO are updated only when a product completes, so MFHI/MFLO always read the last completed result.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH, split into HI (upper) and LO (lower).

Ports:
- clk  in  1  processor clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- start  in  1  level from the decoder; high while the current instruction is MULTU.
- a  in  WIDTH  multiplicand (srca); sampled only on the accepting edge.
- b  in  WIDTH  multiplier (srcb); sampled only on the accepting edge.
- stall  out  1  holds PC/regfile/dmem writes; combinational from state and start.
- busy  out  1  high in RUN.
- done  out  1  single-cycle pulse in DONE.
- hi  out  WIDTH  committed upper product word.
- lo  out  WIDTH  committed lower product word.

## Operation
- State machine: IDLE, RUN, DONE (2-bit register).
- Working registers: mcand (WIDTH), acc (WIDTH), mplr (WIDTH, becomes low product half), cnt (log2(WIDTH) bits).
- IDLE:
  - If start=1: load mcand<=a, mplr<=b, acc<=0, cnt<=0, and go to RUN.
  - Otherwise hold.
- RUN, one iteration per cycle:
  - {c,sum} = acc + (mplr[0] ? mcand : 0), 33-bit add.
  - {acc,mplr} <= {c,sum,mplr[WIDTH-1:1]}, i.e. shift right by one with the carry entering acc[WIDTH-1].
  - cnt <= cnt+1.
- On the RUN edge where cnt==WIDTH-1:
  - Apply the final iteration.
  - Write hi/lo with the post-iteration {acc,mplr}.
  - Go to DONE.
- DONE: go to IDLE unconditionally. start is ignored here. The MULTU retires at this edge and start is still high, so ignoring it prevents a restart.
- Outputs:
  - stall = (IDLE & start) | RUN. DONE deasserts stall.
  - busy = RUN.
  - done = DONE.
- start in RUN or DONE is ignored. Changes on a/b after acceptance are ignored.
- hi/lo change only on the completion edge. They never show partial products and hold indefinitely otherwise.
- Arithmetic is unsigned, and the full 64-bit product is exact with no overflow.
- Async reset while reset=0:
  - State goes to IDLE.
  - hi, lo, acc, mplr, mcand and cnt go to 0.
  - stall follows start, busy=0, done=0.
  - An aborted product is discarded.

## Timing
- Edge E0 (start=1 in IDLE) accepts. E1..E32 are iterations, and E32 writes hi/lo and enters DONE.
- done and the new hi/lo are visible in the cycle after E32, i.e. 33 cycles after acceptance.
- The MULTU instruction occupies 34 cycles: stall is 1 for 33 cycles, then 0 in DONE, then the PC advances.
- Back-to-back MULTU works as follows: DONE to IDLE at E33, and the new instruction's start is seen in IDLE, giving stall=1 combinationally in that same cycle.
- MFHI/MFLO directly after MULTU read the new hi/lo with no extra delay.
- stall is combinational on start. There is no other combinational input-to-output path.

## Test plan
- Reset: reset=0 mid-simulation -> hi=lo=0, busy=0, done=0, stall=start. After release with start=0, all outputs stay 0.
- Basic: a=3, b=5, start held until stall=0 -> stall high 33 cycles, done pulses once exactly 33 cycles after accept, hi=0, lo=15.
- Max operands: a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. Also a=32'h80000000, b=2 -> hi=1, lo=0.
- Operand isolation: accept a=7, b=9, then change a/b to 0 on the next cycle -> hi=0, lo=63. hi/lo hold the previous product (e.g. 15) at every cycle until done.
- Start held through DONE: start stays 1 across DONE -> exactly one product. Start then drops for 1 cycle and rises with a=2, b=4 -> new run, lo=8.
- Reset mid-run: pulse reset=0 at cycle 10 of RUN after an earlier product of 15 -> state IDLE, hi=lo=0, busy=0, no done pulse. A subsequent start runs a full 33-cycle product correctly.

Source files
------------

// File: rtl/multu_seq_if.sv
// Operand/result bundle between the decode/regfile side and the iterative
// multiplier. The pipeline side drives start/a/b and consumes stall/busy/done/hi/lo.
interface multu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, a, b,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, a, b,
    output stall, busy, done, hi, lo
  );
endinterface

// File: rtl/multu_seq.sv
// Iterative unsigned shift-add multiplier with private HI/LO registers.
// One partial-product step per cycle; HI/LO are committed only when the
// last step completes, so readers never observe a partial product.
module multu_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  multu_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0] mplr_q,  mplr_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  // One shift-add step: add the multiplicand when the multiplier LSB is set,
  // then the carry drops into the accumulator MSB as everything shifts right.
  always_comb begin
    addend = mplr_q[0] ? mcand_q : '0;
    sum    = {1'b0, acc_q} + {1'b0, addend};
  end

  // Next-state logic: accept in IDLE, iterate in RUN, commit HI/LO on the last
  // step, and spend one DONE cycle so a still-high start cannot restart.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = bus.a;
          mplr_d  = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = sum[WIDTH:1];
        mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          hi_d    = sum[WIDTH:1];
          lo_d    = {sum[0], mplr_q[WIDTH-1:1]};
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Stall must rise in the same cycle the decoder presents MULTU, hence the
  // combinational start term; DONE releases it so the instruction can retire.
  always_comb begin
    bus.stall = ((state_q == IDLE) && bus.start) || (state_q == RUN);
    bus.busy  = (state_q == RUN);
    bus.done  = (state_q == DONE);
    bus.hi    = hi_q;
    bus.lo    = lo_q;
  end

endmodule

// File: tb/tb_multu_seq.sv
// Scoreboard bench for multu_seq: stimulus pushes the exact 64-bit product
// into a queue; a negedge monitor pops it whenever done pulses and otherwise
// insists HI/LO keep the last committed product.
module tb_multu_seq;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;

  multu_seq_if #(.WIDTH(WIDTH)) bus_if ();

  multu_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  int          checks;
  int          failures;
  logic [63:0] expected_q[$];
  logic [63:0] committed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a done pulse must deliver the oldest pending product; in every
  // other cycle out of reset HI/LO must still show the last committed result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.done) begin
        if (expected_q.size() == 0) begin
          check_output("unexpected_done", 64'd1, 64'd0);
        end else begin
          committed = expected_q.pop_front();
          check_output("product", {bus_if.hi, bus_if.lo}, committed);
        end
      end else begin
        check_output("hilo_hold", {bus_if.hi, bus_if.lo}, committed);
      end
    end
  end

  // One MULTU: start held from accept through DONE, optional operand
  // scrambling after acceptance, optional back-to-back follow-on.
  task automatic apply_stimulus(input logic [31:0] op_a, input logic [31:0] op_b,
                                input bit scramble, input bit back_to_back);
    int n;
    bit got_done;
    bus_if.a     = op_a;
    bus_if.b     = op_b;
    bus_if.start = 1'b1;
    @(negedge clk);
    check_output("accept_stall_busy_done",
                 64'({bus_if.stall, bus_if.busy, bus_if.done}), 64'b100);
    expected_q.push_back(64'(op_a) * 64'(op_b));
    @(posedge clk);
    #1;
    if (scramble) begin
      bus_if.a = $urandom;
      bus_if.b = $urandom;
    end
    n = 0;
    got_done = 1'b0;
    while (!got_done && n < 40) begin
      @(negedge clk);
      n++;
      if (bus_if.done) got_done = 1'b1;
      else if (n < 33)
        check_output("run_stall_busy", 64'({bus_if.stall, bus_if.busy}), 64'b11);
    end
    check_output("done_latency", 64'(n), 64'd33);
    if (got_done)
      check_output("done_stall_busy", 64'({bus_if.stall, bus_if.busy}), 64'b00);
    @(posedge clk);
    #1;
    if (!back_to_back) bus_if.start = 1'b0;
  endtask

  // Idle cycles with start low: nothing may move.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_output("idle_outputs",
                   64'({bus_if.stall, bus_if.busy, bus_if.done}), 64'b000);
    end
    @(posedge clk);
    #1;
  endtask

  // Abort a product partway through RUN with an asynchronous reset.
  task automatic reset_mid_run(input logic [31:0] op_a, input logic [31:0] op_b);
    bus_if.a     = op_a;
    bus_if.b     = op_b;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("rst_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
    check_output("rst_stall_busy_done",
                 64'({bus_if.stall, bus_if.busy, bus_if.done}), 64'b100);
    committed = 64'd0;
    expected_q.delete();
    bus_if.start = 1'b0;
    #1;
    check_output("rst_stall_follows_start", 64'(bus_if.stall), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    checks       = 0;
    failures     = 0;
    committed    = 64'd0;
    rst_n        = 1'b1;
    bus_if.start = 1'b1;
    bus_if.a     = '0;
    bus_if.b     = '0;
    #1;
    rst_n = 1'b0;
    #1;
    check_output("reset_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
    check_output("reset_stall_is_start",
                 64'({bus_if.stall, bus_if.busy, bus_if.done}), 64'b100);
    bus_if.start = 1'b0;
    #1;
    check_output("reset_stall_low", 64'(bus_if.stall), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(3);

    apply_stimulus(32'd3, 32'd5, 1'b0, 1'b0);
    idle_cycles(1);
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle_cycles(1);
    apply_stimulus(32'h8000_0000, 32'd2, 1'b0, 1'b0);
    idle_cycles(1);
    apply_stimulus(32'd3, 32'd5, 1'b0, 1'b0);
    idle_cycles(1);
    apply_stimulus(32'd7, 32'd9, 1'b1, 1'b0);
    idle_cycles(1);
    apply_stimulus(32'd2, 32'd4, 1'b0, 1'b0);
    apply_stimulus(32'd0, $urandom, 1'b0, 1'b1);
    apply_stimulus($urandom, 32'hFFFF_FFFF, 1'b0, 1'b1);
    apply_stimulus(32'd3, 32'd5, 1'b0, 1'b0);
    idle_cycles(1);

    reset_mid_run(32'd11, 32'd13);
    idle_cycles(3);
    apply_stimulus(32'd12345, 32'd6789, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      apply_stimulus(ra, rb, i[0], i[1]);
      if (!i[1]) idle_cycles(1);
    end
    bus_if.start = 1'b0;
    idle_cycles(2);

    check_output("queue_drained", 64'(expected_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
